// File: rtl/sys_cmd_master.sv
// sys_cmd_master: turns one host command into a UART protocol frame, then gathers the reply bytes.
// Latency: the header byte is valid in the cycle after acceptance. The result pulses in the cycle after the last reply byte.
// Backpressure: the TX byte is held stable while tx_busy_i is high. New commands are refused while cmd_busy_o is high.
module sys_cmd_master #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_vld_i,
  input  logic [1:0]  cmd_type_i,
  input  logic [3:0]  cmd_addr_i,
  input  logic [7:0]  cmd_data_i,
  input  logic [7:0]  cmd_opa_i,
  input  logic [7:0]  cmd_opb_i,
  input  logic [3:0]  cmd_fun_i,
  output logic        cmd_busy_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_vld_o,
  input  logic        tx_busy_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_vld_i,
  output logic [15:0] rsp_data_o,
  output logic        rsp_vld_o,
  output logic        rsp_timeout_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_DONE, S_TOUT} state_e;

  state_e      state_q;
  logic [1:0]  type_q;
  logic [3:0]  addr_q;
  logic [7:0]  data_q;
  logic [7:0]  opa_q;
  logic [7:0]  opb_q;
  logic [3:0]  fun_q;
  logic [1:0]  idx_q;
  logic        rx_cnt_q;
  logic [7:0]  byte0_q;
  logic [15:0] cnt_q;
  logic        busy_q;
  logic [7:0]  tx_data_q;
  logic        tx_vld_q;
  logic [15:0] rsp_data_q;
  logic        rsp_vld_q;
  logic        rsp_tout_q;
  logic [7:0]  nxt_byte_d;

  // Byte i of the frame for command type t.
  function automatic logic [7:0] frame_byte(input logic [1:0] t, input logic [1:0] i,
                                            input logic [3:0] a, input logic [7:0] d,
                                            input logic [7:0] oa, input logic [7:0] ob,
                                            input logic [3:0] f);
    logic [7:0] b;
    b = 8'h00;
    case (t)
      2'b00: b = (i == 2'd0) ? 8'hAA : (i == 2'd1) ? {4'h0, a} : d;
      2'b01: b = (i == 2'd0) ? 8'hBB : {4'h0, a};
      2'b10: b = (i == 2'd0) ? 8'hCC : (i == 2'd1) ? oa : (i == 2'd2) ? ob : {4'h0, f};
      default: b = (i == 2'd0) ? 8'hDD : {4'h0, f};
    endcase
    return b;
  endfunction

  // Index of the final frame byte for each command type.
  function automatic logic [1:0] last_idx(input logic [1:0] t);
    case (t)
      2'b00:   return 2'd2;
      2'b10:   return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  // Next frame byte, taken from the fields latched at acceptance.
  always_comb begin
    nxt_byte_d = frame_byte(type_q, idx_q + 2'd1, addr_q, data_q, opa_q, opb_q, fun_q);
  end

  // Command FSM. All outputs are registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      type_q     <= 2'd0;
      addr_q     <= 4'd0;
      data_q     <= 8'd0;
      opa_q      <= 8'd0;
      opb_q      <= 8'd0;
      fun_q      <= 4'd0;
      idx_q      <= 2'd0;
      rx_cnt_q   <= 1'b0;
      byte0_q    <= 8'd0;
      cnt_q      <= 16'd0;
      busy_q     <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_vld_q   <= 1'b0;
      rsp_data_q <= 16'd0;
      rsp_vld_q  <= 1'b0;
      rsp_tout_q <= 1'b0;
    end else begin
      rsp_vld_q  <= 1'b0;
      rsp_tout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_vld_i) begin
            type_q    <= cmd_type_i;
            addr_q    <= cmd_addr_i;
            data_q    <= cmd_data_i;
            opa_q     <= cmd_opa_i;
            opb_q     <= cmd_opb_i;
            fun_q     <= cmd_fun_i;
            idx_q     <= 2'd0;
            tx_data_q <= frame_byte(cmd_type_i, 2'd0, cmd_addr_i, cmd_data_i,
                                    cmd_opa_i, cmd_opb_i, cmd_fun_i);
            tx_vld_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (!tx_busy_i) begin
            if (idx_q == last_idx(type_q)) begin
              tx_vld_q <= 1'b0;
              if (type_q == 2'b00) begin
                rsp_data_q <= 16'h0000;
                rsp_vld_q  <= 1'b1;
                state_q    <= S_DONE;
              end else begin
                cnt_q    <= 16'd0;
                rx_cnt_q <= 1'b0;
                state_q  <= S_WAIT;
              end
            end else begin
              idx_q     <= idx_q + 2'd1;
              tx_data_q <= nxt_byte_d;
            end
          end
        end
        S_WAIT: begin
          // A byte arriving on the expiry edge takes priority over the timeout.
          if (rx_vld_i) begin
            cnt_q <= 16'd0;
            if (!type_q[1]) begin
              rsp_data_q <= {8'h00, rx_data_i};
              rsp_vld_q  <= 1'b1;
              state_q    <= S_DONE;
            end else if (rx_cnt_q) begin
              rsp_data_q <= {rx_data_i, byte0_q};
              rsp_vld_q  <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              byte0_q  <= rx_data_i;
              rx_cnt_q <= 1'b1;
            end
          end else if (cnt_q == TO_LAST) begin
            rsp_tout_q <= 1'b1;
            state_q    <= S_TOUT;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DONE, S_TOUT: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          tx_vld_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_busy_o    = busy_q;
  assign tx_data_o     = tx_data_q;
  assign tx_vld_o      = tx_vld_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_vld_o     = rsp_vld_q;
  assign rsp_timeout_o = rsp_tout_q;

endmodule

// File: tb/tb_sys_cmd_master.sv
// Testbench for sys_cmd_master: a directed vector table, hand-written corner sequences, then random commands.
module tb_sys_cmd_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_vld = 1'b0;
  logic [1:0]  cmd_type = 2'd0;
  logic [3:0]  cmd_addr = 4'd0;
  logic [7:0]  cmd_data = 8'd0;
  logic [7:0]  cmd_opa = 8'd0;
  logic [7:0]  cmd_opb = 8'd0;
  logic [3:0]  cmd_fun = 4'd0;
  logic        cmd_busy;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_vld = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_vld;
  logic        rsp_tout;

  sys_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_vld_i(cmd_vld), .cmd_type_i(cmd_type),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_opa_i(cmd_opa),
    .cmd_opb_i(cmd_opb), .cmd_fun_i(cmd_fun), .cmd_busy_o(cmd_busy),
    .tx_data_o(tx_data), .tx_vld_o(tx_vld), .tx_busy_i(tx_busy),
    .rx_data_i(rx_data), .rx_vld_i(rx_vld), .rsp_data_o(rsp_data),
    .rsp_vld_o(rsp_vld), .rsp_timeout_o(rsp_tout)
  );

  always #5 clk = ~clk;

  // Edge counter: after the n-th rising edge, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int          vld_cnt = 0;
  int          tout_cnt = 0;
  int          pulse_cyc = -1;
  always @(negedge clk) begin
    if (rsp_vld) begin
      vld_cnt   <= vld_cnt + 1;
      pulse_cyc <= cyc;
    end
    if (rsp_tout) begin
      tout_cnt  <= tout_cnt + 1;
      pulse_cyc <= cyc;
    end
  end

  typedef struct packed {
    logic [1:0]  t;
    logic [3:0]  a;
    logic [7:0]  d;
    logic [7:0]  oa;
    logic [7:0]  ob;
    logic [3:0]  f;
    logic [7:0]  stall;   // 0: never busy, 255: random busy, else busy for the first N cycles
    logic [1:0]  nrx;
    logic [7:0]  rb0;
    logic [7:0]  rb1;
    logic [7:0]  g0;
    logic [7:0]  g1;
    logic [2:0]  nb;
    logic [31:0] eb;      // expected frame, first byte in the top octet
    logic [15:0] ersp;
    logic        etout;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] held_rsp = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] eb_at(input logic [31:0] eb, input int i);
    return eb[31-8*i -: 8];
  endfunction

  function automatic vec_t mk(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                              input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f,
                              input logic [7:0] stall, input logic [1:0] nrx,
                              input logic [7:0] rb0, input logic [7:0] rb1,
                              input logic [7:0] g0, input logic [7:0] g1,
                              input logic [2:0] nb, input logic [31:0] eb,
                              input logic [15:0] ersp, input logic etout);
    vec_t v;
    v.t = t; v.a = a; v.d = d; v.oa = oa; v.ob = ob; v.f = f; v.stall = stall;
    v.nrx = nrx; v.rb0 = rb0; v.rb1 = rb1; v.g0 = g0; v.g1 = g1;
    v.nb = nb; v.eb = eb; v.ersp = ersp; v.etout = etout;
    return v;
  endfunction

  // Reference model: builds the frame and the expected result from the protocol rules.
  function automatic vec_t model(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                                 input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f,
                                 input logic [7:0] stall, input logic [1:0] nrx,
                                 input logic [7:0] rb0, input logic [7:0] rb1,
                                 input logic [7:0] g0, input logic [7:0] g1,
                                 input logic [15:0] held);
    vec_t v;
    logic [7:0] q[$];
    int need;
    v = mk(t, a, d, oa, ob, f, stall, nrx, rb0, rb1, g0, g1, 3'd0, 32'd0, 16'd0, 1'b0);
    case (t)
      2'd0: begin q.push_back(8'hAA); q.push_back({4'h0, a}); q.push_back(d); need = 0; end
      2'd1: begin q.push_back(8'hBB); q.push_back({4'h0, a}); need = 1; end
      2'd2: begin q.push_back(8'hCC); q.push_back(oa); q.push_back(ob); q.push_back({4'h0, f}); need = 2; end
      default: begin q.push_back(8'hDD); q.push_back({4'h0, f}); need = 2; end
    endcase
    v.nb = 3'(q.size());
    foreach (q[i]) v.eb[31-8*i -: 8] = q[i];
    v.etout = (int'(nrx) < need);
    if (v.etout)        v.ersp = held;
    else if (need == 0) v.ersp = 16'h0000;
    else if (need == 1) v.ersp = {8'h00, rb0};
    else                v.ersp = {rb1, rb0};
    return v;
  endfunction

  task automatic junk_cmd();
    cmd_type = 2'($urandom); cmd_addr = 4'($urandom); cmd_data = 8'($urandom);
    cmd_opa = 8'($urandom); cmd_opb = 8'($urandom); cmd_fun = 4'($urandom);
  endtask

  // Issues one command, drives the transmitter side and the replies, and checks the outcome.
  task automatic run_cmd(input vec_t v, input bit hold_vld);
    int k, e, m, exp_pulse, v0, t0, got, stalls, guard;
    bit stalled;
    logic [7:0] held;
    @(posedge clk); #1;
    cmd_vld = 1'b1; cmd_type = v.t; cmd_addr = v.a; cmd_data = v.d;
    cmd_opa = v.oa; cmd_opb = v.ob; cmd_fun = v.f;
    @(negedge clk);
    chk("idle_before_accept", 32'(cmd_busy), 32'd0);
    v0 = vld_cnt; t0 = tout_cnt;
    @(posedge clk); #1;
    k = cyc;
    cmd_vld = hold_vld;   // held high with junk: must not be accepted while busy
    junk_cmd();
    got = 0; stalls = 0; stalled = 1'b0; guard = 0; held = 8'h00;
    while (got < int'(v.nb) && guard < 300) begin
      guard++;
      if (v.stall == 8'd255) tx_busy = ($urandom_range(0, 2) == 0);
      else                   tx_busy = (stalls < int'(v.stall));
      rx_vld = ($urandom_range(0, 3) == 0);
      rx_data = 8'($urandom);
      @(negedge clk);
      chk("tx_vld", 32'(tx_vld), 32'd1);
      if (stalled) chk("tx_hold", 32'(tx_data), 32'(held));
      if (tx_busy) begin
        stalls++; stalled = 1'b1; held = tx_data;
      end else begin
        chk("tx_byte", 32'(tx_data), 32'(eb_at(v.eb, got)));
        if (v.stall == 8'd0) chk("tx_cycle", 32'(cyc), 32'(k + got));
        got++; stalled = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("tx_frame_len", 32'(got), 32'(v.nb));
    tx_busy = 1'b0; rx_vld = 1'b0;
    e = cyc;
    m = e;
    if (v.t != 2'd0) begin
      for (int i = 0; i < int'(v.nrx); i++) begin
        repeat (int'((i == 0) ? v.g0 : v.g1)) begin @(posedge clk); #1; end
        rx_vld = 1'b1; rx_data = (i == 0) ? v.rb0 : v.rb1;
        @(posedge clk); #1;
        rx_vld = 1'b0; rx_data = 8'($urandom);
        m = cyc;
      end
    end
    exp_pulse = v.etout ? (m + TO) : ((v.t == 2'd0) ? e : m);
    guard = 0;
    do begin @(negedge clk); guard++; end while (cmd_busy && guard < 100);
    cmd_vld = 1'b0;
    chk("busy_fall", 32'(cmd_busy), 32'd0);
    chk("busy_fall_cyc", 32'(cyc), 32'(exp_pulse + 1));
    #1;
    chk("rsp_vld_pulses", 32'(vld_cnt - v0), v.etout ? 32'd0 : 32'd1);
    chk("tout_pulses", 32'(tout_cnt - t0), v.etout ? 32'd1 : 32'd0);
    chk("pulse_cyc", 32'(pulse_cyc), 32'(exp_pulse));
    chk("rsp_data", 32'(rsp_data), 32'(v.ersp));
    held_rsp = v.ersp;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(cmd_busy), 32'd0);
    chk({tag, "_txvld"}, 32'(tx_vld),   32'd0);
    chk({tag, "_txdat"}, 32'(tx_data),  32'd0);
    chk({tag, "_rsp"},   32'(rsp_data), 32'd0);
    chk({tag, "_rvld"},  32'(rsp_vld),  32'd0);
    chk({tag, "_rto"},   32'(rsp_tout), 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    int v0, t0;
    int need;
    logic [1:0] t, nrx;

    // Inputs, then expected frame length, frame bytes, result and timeout flag.
    tbl[0] = mk(2'd0, 4'hC, 8'h14, 8'h00, 8'h00, 4'h0, 8'd0,   2'd0, 8'h00, 8'h00, 8'd0, 8'd0, 3'd3, 32'hAA0C1400, 16'h0000, 1'b0);
    tbl[1] = mk(2'd1, 4'hC, 8'h00, 8'h00, 8'h00, 4'h0, 8'd5,   2'd1, 8'h14, 8'h00, 8'd2, 8'd0, 3'd2, 32'hBB0C0000, 16'h0014, 1'b0);
    tbl[2] = mk(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2, 8'd0,   2'd2, 8'h46, 8'h00, 8'd1, 8'd3, 3'd4, 32'hCC123402, 16'h0046, 1'b0);
    tbl[3] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h5, 8'd0,   2'd1, 8'h77, 8'h00, 8'd0, 8'd0, 3'd2, 32'hDD050000, 16'h0046, 1'b1);
    tbl[4] = mk(2'd0, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0, 8'd255, 2'd0, 8'h00, 8'h00, 8'd0, 8'd0, 3'd3, 32'hAA035A00, 16'h0000, 1'b0);
    tbl[5] = mk(2'd1, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0, 8'd0,   2'd1, 8'hA5, 8'h00, 8'd7, 8'd0, 3'd2, 32'hBB070000, 16'h00A5, 1'b0);
    tbl[6] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hF, 8'd255, 2'd2, 8'h11, 8'h22, 8'd7, 8'd7, 3'd2, 32'hDD0F0000, 16'h2211, 1'b0);
    tbl[7] = mk(2'd2, 4'h0, 8'h00, 8'hFF, 8'h01, 4'h0, 8'd0,   2'd0, 8'h00, 8'h00, 8'd0, 8'd0, 3'd4, 32'hCCFF0100, 16'h2211, 1'b1);

    // Reset state.
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_cmd(tbl[i], 1'b1);

    // Stray reply bytes while idle must not leak into the next read.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; rx_vld = 1'b1; rx_data = 8'hEE;
    end
    @(posedge clk); #1; rx_vld = 1'b0;
    chk("stray_idle_busy", 32'(cmd_busy), 32'd0);
    run_cmd(mk(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 8'd0, 2'd1, 8'h55, 8'h00, 8'd0, 8'd0,
               3'd2, 32'hBB020000, 16'h0055, 1'b0), 1'b0);

    // Reset in the middle of a CC frame, while the second byte is on the bus.
    @(posedge clk); #1;
    cmd_vld = 1'b1; cmd_type = 2'd2; cmd_opa = 8'h12; cmd_opb = 8'h34; cmd_fun = 4'h2;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    @(posedge clk); #1;
    chk("mid_second_byte", 32'(tx_data), 32'h12);
    v0 = vld_cnt; t0 = tout_cnt;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_pulse", 32'(vld_cnt - v0 + tout_cnt - t0), 32'd0);
    chk("midrst_idle", 32'(cmd_busy), 32'd0);
    held_rsp = 16'h0000;
    run_cmd(mk(2'd0, 4'h9, 8'hC3, 8'h00, 8'h00, 4'h0, 8'd0, 2'd0, 8'h00, 8'h00, 8'd0, 8'd0,
               3'd3, 32'hAA09C300, 16'h0000, 1'b0), 1'b0);

    // Random commands against the reference model.
    for (int n = 0; n < 150; n++) begin
      t = 2'($urandom_range(0, 3));
      need = (t == 2'd0) ? 0 : (t == 2'd1) ? 1 : 2;
      nrx = 2'(need);
      if (need > 0 && $urandom_range(0, 4) == 0) nrx = 2'($urandom_range(0, need - 1));
      v = model(t, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                ($urandom_range(0, 3) == 0) ? 8'd0 : 8'd255, nrx,
                8'($urandom), 8'($urandom), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                held_rsp);
      run_cmd(v, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
